// File: rtl/stack_control_unit.sv
// Stack controller: sequences PUSH/POP against data memory and commits the new $rp to the register bank.
// Optional bounds checking (overflow/underflow -> ERR) is enabled by defining STACK_BOUNDS_CHECK_EN.
module stack_control_unit #(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] RP_INIT     = DATA_W'(224),
    parameter logic [DATA_W-1:0] STACK_LIMIT = DATA_W'(160),
    parameter logic [DATA_W-1:0] STEP        = DATA_W'(1)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] rp_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    output logic [DATA_W-1:0] rp_o,
    output logic              pilha_e_o,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              done_o,
    output logic              err_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH_WR, S_POP_RD, S_POP_WAIT, S_UPDATE, S_ERR
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] rp_q;
    logic [DATA_W-1:0] mem_addr_q, mem_wdata_q, rp_out_q, pop_data_q;
    logic              mem_we_q, mem_re_q, pilha_e_q, done_q, busy_q;

    logic push_req, pop_req, bad;
    assign push_req = start_i && (op_i == 2'b01);
    assign pop_req  = start_i && (op_i == 2'b10);

`ifdef STACK_BOUNDS_CHECK_EN
    logic err_q;
    assign bad   = (push_req && (rp_i < STACK_LIMIT + STEP)) ||
                   (pop_req && (rp_i >= RP_INIT));
    assign err_o = err_q;
`else
    assign bad   = 1'b0;
    assign err_o = 1'b0;
`endif

    // Outputs are registered, so each state loads the values seen during the following state.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            rp_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rp_out_q    <= '0;
            pop_data_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            pilha_e_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            mem_we_q  <= 1'b0;
            mem_re_q  <= 1'b0;
            pilha_e_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
            err_q     <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (bad) begin
                        rp_q    <= rp_i;
                        busy_q  <= 1'b1;
                        state_q <= S_ERR;
`ifdef STACK_BOUNDS_CHECK_EN
                        err_q   <= 1'b1;
`endif
                    end else if (push_req) begin
                        rp_q        <= rp_i;
                        mem_addr_q  <= rp_i - STEP;
                        mem_wdata_q <= push_data_i;
                        mem_we_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_PUSH_WR;
                    end else if (pop_req) begin
                        rp_q       <= rp_i;
                        mem_addr_q <= rp_i;
                        mem_re_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_POP_RD;
                    end
                end
                S_PUSH_WR: begin
                    rp_out_q  <= rp_q - STEP;
                    pilha_e_q <= 1'b1;
                    done_q    <= 1'b1;
                    state_q   <= S_UPDATE;
                end
                S_POP_RD: state_q <= S_POP_WAIT;
                S_POP_WAIT: begin
                    pop_data_q <= mem_rdata_i;
                    rp_out_q   <= rp_q + STEP;
                    pilha_e_q  <= 1'b1;
                    done_q     <= 1'b1;
                    state_q    <= S_UPDATE;
                end
                S_UPDATE, S_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;
    assign mem_re_o    = mem_re_q;
    assign rp_o        = rp_out_q;
    assign pilha_e_o   = pilha_e_q;
    assign pop_data_o  = pop_data_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_stack_control_unit.sv
// Bench for stack_control_unit: directed cases plus random traffic against a transaction-level model.
module tb_stack_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rp_in = '0, push_data = '0, mem_rdata = '0;
    logic [31:0] mem_addr, mem_wdata, rp_out, pop_data;
    logic        mem_we, mem_re, pilha_e, done, err, busy;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    stack_control_unit dut (
        .clock_i(clk), .reset_i(rst), .start_i(start), .op_i(op),
        .rp_i(rp_in), .push_data_i(push_data), .mem_rdata_i(mem_rdata),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
        .mem_re_o(mem_re), .rp_o(rp_out), .pilha_e_o(pilha_e),
        .pop_data_o(pop_data), .done_o(done), .err_o(err), .busy_o(busy)
    );

    // Contents of never-written words: a fixed scramble of the address.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    // Data memory seen by the DUT: one-cycle read latency.
    logic [31:0] dmem [logic [31:0]];
    always @(posedge clk) begin
        if (mem_we) dmem[mem_addr] = mem_wdata;
        if (mem_re) mem_rdata <= dmem.exists(mem_addr) ? dmem[mem_addr] : dflt(mem_addr);
    end

    typedef struct packed {
        logic busy, err, done, pilha, we, re;
        logic [31:0] addr, wdata, rp, pd;
    } vec_t;

    // Model: on each accepted request, the whole per-cycle output sequence is planned up front.
    vec_t        exp_v = '0;
    vec_t        plan[$];
    logic [31:0] mmem [logic [31:0]];

    function automatic logic [31:0] mread(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : dflt(a);
    endfunction

    task automatic plan_req(input logic [1:0] o, input logic [31:0] rp, input logic [31:0] d);
        vec_t b, e1, e2, e3;
        logic bad;
        b = exp_v;
        {b.busy, b.err, b.done, b.pilha, b.we, b.re} = 6'b100000;
`ifdef STACK_BOUNDS_CHECK_EN
        bad = (o == 2'd1) ? (rp < 32'd161) : (rp >= 32'd224);
`else
        bad = 1'b0;
`endif
        if (bad) begin
            e1 = b; e1.err = 1'b1;
            plan.push_back(e1);
        end else if (o == 2'd1) begin
            e1 = b; e1.we = 1'b1; e1.addr = rp - 32'd1; e1.wdata = d;
            e2 = e1; e2.we = 1'b0; e2.pilha = 1'b1; e2.done = 1'b1; e2.rp = rp - 32'd1;
            plan.push_back(e1); plan.push_back(e2);
            mmem[rp - 32'd1] = d;
        end else begin
            e1 = b; e1.re = 1'b1; e1.addr = rp;
            e2 = e1; e2.re = 1'b0;
            e3 = e2; e3.pilha = 1'b1; e3.done = 1'b1; e3.rp = rp + 32'd1; e3.pd = mread(rp);
            plan.push_back(e1); plan.push_back(e2); plan.push_back(e3);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_v = '0;
            plan.delete();
        end else begin
            if (plan.size() == 0 && !exp_v.busy && start && (op == 2'd1 || op == 2'd2))
                plan_req(op, rp_in, push_data);
            if (plan.size() > 0) exp_v = plan.pop_front();
            else {exp_v.busy, exp_v.err, exp_v.done, exp_v.pilha, exp_v.we, exp_v.re} = '0;
        end
    end

    vec_t act_v;
    assign act_v = '{busy, err, done, pilha_e, mem_we, mem_re, mem_addr, mem_wdata, rp_out, pop_data};

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (act_v === exp_v) passed++;
            else $display("FAIL cycle t=%0t act=%h exp=%h", $time, act_v, exp_v);
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s act=%h exp=%h", name, act, expv);
    endtask

    task automatic req(input logic [1:0] o, input logic [31:0] rp, input logic [31:0] d);
        @(negedge clk);
        start = 1'b1; op = o; rp_in = rp; push_data = d;
        @(negedge clk);
        start = 1'b0; op = 2'b00;
    endtask

    int cnt;
    logic [31:0] picks [10];

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        lit("reset_outs", {mem_addr | mem_wdata | rp_out | pop_data}, 32'd0);
        lit("reset_ctl", {26'd0, busy, err, done, pilha_e, mem_we, mem_re}, 32'd0);
        rst = 1'b0;

        // Asynchronous reset mid-cycle while a pop is in flight
        req(2'd2, 32'd200, 32'd0);
        #2 rst = 1'b1;
        #1 lit("async_rst_ctl", {26'd0, busy, err, done, pilha_e, mem_we, mem_re}, 32'd0);
        lit("async_rst_addr", mem_addr, 32'd0);
        @(negedge clk) rst = 1'b0;

        // Push
        req(2'd1, 32'd224, 32'hDEADBEEF);
        lit("push_we", {31'd0, mem_we}, 32'd1);
        lit("push_addr", mem_addr, 32'd223);
        lit("push_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        lit("push_pilha", {31'd0, pilha_e}, 32'd1);
        lit("push_rp", rp_out, 32'd223);
        lit("push_done", {31'd0, done}, 32'd1);
        @(negedge clk);

        // Pop after push
        req(2'd2, 32'd223, 32'd0);
        lit("pop_re", {31'd0, mem_re}, 32'd1);
        lit("pop_addr", mem_addr, 32'd223);
        repeat (2) @(negedge clk);
        lit("pop_pilha", {31'd0, pilha_e}, 32'd1);
        lit("pop_rp", rp_out, 32'd224);
        lit("pop_done", {31'd0, done}, 32'd1);
        lit("pop_data", pop_data, 32'hDEADBEEF);
        @(negedge clk);

        // Bounds
`ifdef STACK_BOUNDS_CHECK_EN
        req(2'd2, 32'd224, 32'd0);
        lit("underflow_err", {29'd0, err, mem_re, pilha_e}, 32'd4);
        @(negedge clk);
        req(2'd1, 32'd160, 32'd7);
        lit("overflow_err", {30'd0, err, mem_we}, 32'd2);
        @(negedge clk);
        lit("err_rp_kept", rp_out, 32'd224);
`else
        req(2'd2, 32'd224, 32'd0);
        repeat (2) @(negedge clk);
        lit("nochk_pop_rp", rp_out, 32'd225);
        lit("nochk_pop_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        req(2'd1, 32'd160, 32'd7);
        @(negedge clk);
        lit("nochk_push_rp", rp_out, 32'd159);
        lit("nochk_err", {31'd0, err}, 32'd0);
        @(negedge clk);
`endif

        // start while busy is dropped; op=11 in IDLE is ignored
        req(2'd1, 32'd200, 32'd1);
        start = 1'b1; op = 2'd2; rp_in = 32'd200;
        cnt = 0;
        repeat (2) begin cnt += int'(done); @(negedge clk); end
        start = 1'b0; op = 2'd0;
        repeat (3) begin cnt += int'(done); @(negedge clk); end
        lit("busy_start_done_cnt", cnt, 32'd1);
        start = 1'b1; op = 2'd3;
        @(negedge clk);
        start = 1'b0; op = 2'd0;
        lit("op11_busy", {31'd0, busy}, 32'd0);

        // Reset during POP_WAIT, then a clean push
        req(2'd2, 32'd200, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 lit("popwait_rst", {26'd0, busy, err, done, pilha_e, mem_we, mem_re}, 32'd0);
        lit("popwait_rst_rp", rp_out, 32'd0);
        @(negedge clk) rst = 1'b0;
        cnt = 0;
        repeat (4) begin @(negedge clk); cnt += int'(pilha_e | done); end
        lit("post_rst_quiet", cnt, 32'd0);
        req(2'd1, 32'd224, 32'hCAFEF00D);
        @(negedge clk);
        lit("post_rst_done", {31'd0, done}, 32'd1);
        lit("post_rst_rp", rp_out, 32'd223);
        @(negedge clk);

        // Random traffic
        picks = '{32'd0, 32'd1, 32'd159, 32'd160, 32'd161, 32'd162,
                  32'd223, 32'd224, 32'd225, 32'hFFFFFFFF};
        repeat (3000) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3));
            rp_in = ($urandom_range(0, 2) == 0) ? picks[$urandom_range(0, 9)]
                                                : 32'($urandom_range(150, 230));
            push_data = $urandom;
        end
        start = 1'b0; op = 2'd0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
